// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register slave: NUM_REGS-1 read/write registers with byte strobes
// plus one read-only status word at the top index. Independent read and write
// FSMs; every response is registered.
module axi_lite_slave_regs #(
    parameter int unsigned NUM_REGS  = 8,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst,
    // write address channel
    input  logic [31:0]                   s_axi_lite_awaddr_i,
    input  logic                          s_axi_lite_awvalid_i,
    output logic                          s_axi_lite_awready_o,
    // write data channel
    input  logic [31:0]                   s_axi_lite_wdata_i,
    input  logic [3:0]                    s_axi_lite_wstrb_i,
    input  logic                          s_axi_lite_wvalid_i,
    output logic                          s_axi_lite_wready_o,
    // write response channel
    output logic [1:0]                    s_axi_lite_bresp_o,
    output logic                          s_axi_lite_bvalid_o,
    input  logic                          s_axi_lite_bready_i,
    // read address channel
    input  logic [31:0]                   s_axi_lite_araddr_i,
    input  logic                          s_axi_lite_arvalid_i,
    output logic                          s_axi_lite_arready_o,
    // read data channel
    output logic [31:0]                   s_axi_lite_rdata_o,
    output logic [1:0]                    s_axi_lite_rresp_o,
    output logic                          s_axi_lite_rvalid_o,
    input  logic                          s_axi_lite_rready_i,
    // register side
    output logic [32*(NUM_REGS-1)-1:0]    regs_o,
    output logic [NUM_REGS-2:0]           wr_pulse_o,
    input  logic [31:0]                   status_i
);

    localparam int unsigned IW          = $clog2(NUM_REGS);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    // write path state
    wstate_t                     wstate_q, wstate_d;
    logic                        aw_vld_q, aw_vld_d;
    logic [31:2]                 aw_addr_q, aw_addr_d;
    logic                        w_vld_q, w_vld_d;
    logic [31:0]                 w_data_q, w_data_d;
    logic [3:0]                  w_strb_q, w_strb_d;
    logic                        bvalid_q, bvalid_d;
    logic [1:0]                  bresp_q, bresp_d;
    logic [NUM_REGS-2:0]         wr_pulse_q, wr_pulse_d;
    logic [NUM_REGS-2:0][31:0]   regs_q, regs_d;

    // read path state
    rstate_t                     rstate_q, rstate_d;
    logic                        rvalid_q, rvalid_d;
    logic [31:0]                 rdata_q, rdata_d;
    logic [1:0]                  rresp_q, rresp_d;

    logic                        awready, wready;
    logic [IW-1:0]               w_idx, r_idx;
    logic                        w_oor, w_err, r_oor;

    // Byte offset bits of both addresses are don't-care.
    logic                        unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_axi_lite_awaddr_i[1:0], s_axi_lite_araddr_i[1:0]};

    assign awready = (wstate_q == W_IDLE) && !aw_vld_q;
    assign wready  = (wstate_q == W_IDLE) && !w_vld_q;

    // Write FSM: latch AW and W independently, apply the write once both are held, then respond.
    always_comb begin
        wstate_d   = wstate_q;
        aw_vld_d   = aw_vld_q;
        aw_addr_d  = aw_addr_q;
        w_vld_d    = w_vld_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;

        w_idx = aw_addr_q[2 +: IW];
        w_oor = |aw_addr_q[31:2+IW];
        w_err = w_oor || (w_idx == IW'(NUM_REGS-1));

        case (wstate_q)
            W_IDLE: begin
                if (aw_vld_q && w_vld_q) begin
                    aw_vld_d = 1'b0;
                    w_vld_d  = 1'b0;
                    bvalid_d = 1'b1;
                    bresp_d  = w_err ? RESP_SLVERR : RESP_OKAY;
                    wstate_d = W_RESP;
                    if (!w_err) begin
                        for (int unsigned i = 0; i < NUM_REGS-1; i++) begin
                            if (w_idx == IW'(i)) begin
                                for (int unsigned b = 0; b < 4; b++) begin
                                    if (w_strb_q[b]) begin
                                        regs_d[i][8*b +: 8] = w_data_q[8*b +: 8];
                                    end
                                end
                                wr_pulse_d[i] = |w_strb_q;
                            end
                        end
                    end
                end else begin
                    if (s_axi_lite_awvalid_i && awready) begin
                        aw_vld_d  = 1'b1;
                        aw_addr_d = s_axi_lite_awaddr_i[31:2];
                    end
                    if (s_axi_lite_wvalid_i && wready) begin
                        w_vld_d  = 1'b1;
                        w_data_d = s_axi_lite_wdata_i;
                        w_strb_d = s_axi_lite_wstrb_i;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_lite_bready_i) begin
                    bvalid_d = 1'b0;
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Write path registers; reset drops any half-latched or pending transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q   <= W_IDLE;
            aw_vld_q   <= 1'b0;
            aw_addr_q  <= '0;
            w_vld_q    <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            regs_q     <= {(NUM_REGS-1){RESET_VAL}};
        end else begin
            wstate_q   <= wstate_d;
            aw_vld_q   <= aw_vld_d;
            aw_addr_q  <= aw_addr_d;
            w_vld_q    <= w_vld_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
        end
    end

    // Read FSM: capture data at the AR handshake (pre-write value on a collision), hold until rready.
    always_comb begin
        rstate_d = rstate_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;

        r_idx = s_axi_lite_araddr_i[2 +: IW];
        r_oor = |s_axi_lite_araddr_i[31:2+IW];

        case (rstate_q)
            R_IDLE: begin
                if (s_axi_lite_arvalid_i) begin
                    rvalid_d = 1'b1;
                    rstate_d = R_DATA;
                    rdata_d  = '0;
                    if (r_oor) begin
                        rresp_d = RESP_SLVERR;
                    end else begin
                        rresp_d = RESP_OKAY;
                        if (r_idx == IW'(NUM_REGS-1)) begin
                            rdata_d = status_i;
                        end else begin
                            for (int unsigned i = 0; i < NUM_REGS-1; i++) begin
                                if (r_idx == IW'(i)) begin
                                    rdata_d = regs_q[i];
                                end
                            end
                        end
                    end
                end
            end
            R_DATA: begin
                if (s_axi_lite_rready_i) begin
                    rvalid_d = 1'b0;
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Read path registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q <= R_IDLE;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rstate_q <= rstate_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

    // Responses and strobes are forced low for as long as rst is held, not just after its first edge.
    assign s_axi_lite_awready_o = awready;
    assign s_axi_lite_wready_o  = wready;
    assign s_axi_lite_bvalid_o  = bvalid_q & ~rst;
    assign s_axi_lite_bresp_o   = rst ? '0 : bresp_q;
    assign s_axi_lite_arready_o = (rstate_q == R_IDLE);
    assign s_axi_lite_rvalid_o  = rvalid_q & ~rst;
    assign s_axi_lite_rdata_o   = rst ? '0 : rdata_q;
    assign s_axi_lite_rresp_o   = rst ? '0 : rresp_q;
    assign wr_pulse_o           = rst ? '0 : wr_pulse_q;
    assign regs_o               = regs_q;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed bench for axi_lite_slave_regs (NUM_REGS=8, RESET_VAL=0).
module tb_axi_lite_slave_regs;

    localparam int unsigned NR = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        awaddr, wdata, araddr, rdata, status;
    logic               awvalid, awready, wvalid, wready;
    logic [3:0]         wstrb;
    logic [1:0]         bresp, rresp;
    logic               bvalid, bready, arvalid, arready, rvalid, rready;
    logic [32*(NR-1)-1:0] regs;
    logic [NR-2:0]      wr_pulse;

    int unsigned        n_checks = 0;
    int unsigned        n_fail   = 0;
    logic [31:0]        exp_regs [NR-1];

    always #5 clk = ~clk;

    axi_lite_slave_regs #(.NUM_REGS(NR), .RESET_VAL(32'h0000_0000)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .s_axi_lite_awaddr_i  (awaddr),
        .s_axi_lite_awvalid_i (awvalid),
        .s_axi_lite_awready_o (awready),
        .s_axi_lite_wdata_i   (wdata),
        .s_axi_lite_wstrb_i   (wstrb),
        .s_axi_lite_wvalid_i  (wvalid),
        .s_axi_lite_wready_o  (wready),
        .s_axi_lite_bresp_o   (bresp),
        .s_axi_lite_bvalid_o  (bvalid),
        .s_axi_lite_bready_i  (bready),
        .s_axi_lite_araddr_i  (araddr),
        .s_axi_lite_arvalid_i (arvalid),
        .s_axi_lite_arready_o (arready),
        .s_axi_lite_rdata_o   (rdata),
        .s_axi_lite_rresp_o   (rresp),
        .s_axi_lite_rvalid_o  (rvalid),
        .s_axi_lite_rready_i  (rready),
        .regs_o               (regs),
        .wr_pulse_o           (wr_pulse),
        .status_i             (status)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR-1; i++) begin
            check($sformatf("%s_reg%0d", tag, i), regs[32*i +: 32], exp_regs[i]);
        end
    endtask

    // AW and W in the same cycle; returns the response and the strobe seen with bvalid.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [NR-2:0] pulse);
        bit seen = 0;
        awaddr = a; awvalid = 1'b1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        resp = 2'bxx; pulse = 'x;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (bvalid) begin
                seen = 1;
                resp = bresp;
                pulse = wr_pulse;
            end
        end
        if (!seen) check("wr_timeout", 32'd0, 32'd1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit seen = 0;
        araddr = a; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        d = 'x; resp = 2'bxx;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (rvalid) begin
                seen = 1;
                d = rdata;
                resp = rresp;
            end else begin
                tick();
            end
        end
        if (!seen) check("rd_timeout", 32'd0, 32'd1);
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]      resp;
        logic [NR-2:0]   pulse;
        logic [31:0]     rd;

        rst = 1'b1;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0; status = '0;
        for (int i = 0; i < NR-1; i++) exp_regs[i] = 32'h0;

        // reset state
        tick();
        tick();
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_pulse", {25'd0, wr_pulse}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        #1;
        check("rel_readies", {29'd0, awready, wready, arready}, 32'd7);
        check_regs("rst");

        // AW and W together to reg1
        awaddr = 32'h04; awvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        check("t1_bvalid_early", {31'd0, bvalid}, 32'd0);
        tick();
        check("t1_bvalid", {31'd0, bvalid}, 32'd1);
        check("t1_bresp", {30'd0, bresp}, 32'd0);
        check("t1_pulse", {25'd0, wr_pulse}, 32'h02);
        check("t1_reg1", regs[63:32], 32'hDEADBEEF);
        check("t1_awready_resp", {31'd0, awready}, 32'd0);
        tick();
        check("t1_pulse_once", {25'd0, wr_pulse}, 32'd0);
        check("t1_bvalid_hold", {31'd0, bvalid}, 32'd1);
        bready = 1;
        tick();
        bready = 0;
        check("t1_bvalid_clr", {31'd0, bvalid}, 32'd0);
        exp_regs[1] = 32'hDEADBEEF;

        // W three cycles ahead of AW, partial strobe into reg2
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1;
        tick();
        wvalid = 0;
        check("t2_wready_held", {30'd0, awready, wready}, 32'b10);
        tick();
        tick();
        check("t2_no_resp_yet", {31'd0, bvalid}, 32'd0);
        awaddr = 32'h08; awvalid = 1;
        tick();
        awvalid = 0;
        tick();
        check("t2_bvalid", {31'd0, bvalid}, 32'd1);
        check("t2_bresp", {30'd0, bresp}, 32'd0);
        check("t2_pulse", {25'd0, wr_pulse}, 32'h04);
        check("t2_reg2", regs[95:64], 32'h00220044);
        bready = 1;
        tick();
        bready = 0;
        exp_regs[2] = 32'h00220044;

        // error writes and status read
        axi_write(32'h20, 32'hFFFF_FFFF, 4'hF, resp, pulse);
        check("t3_oor_bresp", {30'd0, resp}, 32'd2);
        check("t3_oor_pulse", {25'd0, pulse}, 32'd0);
        axi_write(32'h1C, 32'hFFFF_FFFF, 4'hF, resp, pulse);
        check("t3_ro_bresp", {30'd0, resp}, 32'd2);
        check("t3_ro_pulse", {25'd0, pulse}, 32'd0);
        check_regs("t3");
        status = 32'hCAFE0001;
        axi_read(32'h1C, rd, resp);
        check("t3_status_rdata", rd, 32'hCAFE0001);
        check("t3_status_rresp", {30'd0, resp}, 32'd0);
        axi_read(32'h40, rd, resp);
        check("t3_oor_rdata", rd, 32'd0);
        check("t3_oor_rresp", {30'd0, resp}, 32'd2);

        // zero strobe: OKAY, nothing written, no strobe
        axi_write(32'h00, 32'hFFFF_FFFF, 4'h0, resp, pulse);
        check("t4_zstrb_bresp", {30'd0, resp}, 32'd0);
        check("t4_zstrb_pulse", {25'd0, pulse}, 32'd0);
        check("t4_zstrb_reg0", regs[31:0], 32'd0);

        // low address bits ignored
        axi_read(32'h07, rd, resp);
        check("t5_lsb_rdata", rd, 32'hDEADBEEF);

        // rready back-pressure
        araddr = 32'h04; arvalid = 1;
        tick();
        arvalid = 0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t6_rvalid_%0d", i), {31'd0, rvalid}, 32'd1);
            check($sformatf("t6_rdata_%0d", i), rdata, 32'hDEADBEEF);
            check($sformatf("t6_arready_%0d", i), {31'd0, arready}, 32'd0);
            tick();
        end
        rready = 1;
        tick();
        rready = 0;
        check("t6_rvalid_clr", {31'd0, rvalid}, 32'd0);
        check("t6_arready_back", {31'd0, arready}, 32'd1);

        // read/write collision on reg3
        axi_write(32'h0C, 32'h77, 4'hF, resp, pulse);
        check("t7_pre_pulse", {25'd0, pulse}, 32'h08);
        awaddr = 32'h0C; awvalid = 1; wdata = 32'h5; wstrb = 4'hF; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        araddr = 32'h0C; arvalid = 1;
        tick();
        arvalid = 0;
        check("t7_bvalid", {31'd0, bvalid}, 32'd1);
        check("t7_rvalid", {31'd0, rvalid}, 32'd1);
        check("t7_old_rdata", rdata, 32'h77);
        check("t7_reg3_new", regs[127:96], 32'h5);
        rready = 1; bready = 1;
        tick();
        rready = 0; bready = 0;
        axi_read(32'h0C, rd, resp);
        check("t7_new_rdata", rd, 32'h5);
        exp_regs[3] = 32'h5;
        check_regs("t7");

        // reset while bvalid pending
        awaddr = 32'h00; awvalid = 1; wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        tick();
        check("t8_bvalid_pend", {31'd0, bvalid}, 32'd1);
        check("t8_reg0_written", regs[31:0], 32'h12345678);
        rst = 1;
        tick();
        check("t8_bvalid_rst", {31'd0, bvalid}, 32'd0);
        for (int i = 0; i < NR-1; i++) exp_regs[i] = 32'h0;
        check_regs("t8");
        rst = 0;
        bready = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t8_no_resp_%0d", i), {31'd0, bvalid}, 32'd0);
        end
        bready = 0;
        check("t8_readies", {29'd0, awready, wready, arready}, 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_slave_regs.md
AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, giving the number of 32-bit registers (power of two, 2..256); index NUM_REGS-1 is read-only status.
REQ-002 SHALL have parameter RESET_VAL, default 32'h0000_0000, giving the reset value of every read/write register.
REQ-003 SHALL have ports clk input 1 (the single clock) and rst input 1 (synchronous, active-high reset); this clocking and reset scheme is fixed.
REQ-004 SHALL have write-address ports: s_axi_lite.awaddr in 32, awvalid in 1, awready out 1.
REQ-005 SHALL have write-data ports: s_axi_lite.wdata in 32, wstrb in 4, wvalid in 1, wready out 1.
REQ-006 SHALL have write-response ports: s_axi_lite.bresp out 2, bvalid out 1, bready in 1.
REQ-007 SHALL have read-address ports: s_axi_lite.araddr in 32, arvalid in 1, arready out 1.
REQ-008 SHALL have read-data ports: s_axi_lite.rdata out 32, rresp out 2, rvalid out 1, rready in 1.
REQ-009 SHALL have ports regs_o out 32*(NUM_REGS-1) (flat register contents, reg i at bits [32i+:32]), wr_pulse_o out NUM_REGS-1 (one-cycle strobe per register written), and status_i in 32 (value returned at index NUM_REGS-1).

Function
REQ-010 SHALL decode index = addr[2+:log2(NUM_REGS)], ignore addr[1:0], and treat addr >= 4*NUM_REGS as out-of-range.
REQ-011 SHALL encode responses as OKAY = 2'b00 and SLVERR = 2'b10.
REQ-012 SHALL implement a write FSM with states W_IDLE and W_RESP.
REQ-013 SHALL, in W_IDLE, assert awready while no address is latched and wready while no data is latched, and accept AW and W independently in any order or in the same cycle.
REQ-014 SHALL, in the cycle after both AW and W are latched, perform the write, pulse the matching wr_pulse_o bit for one cycle, drive bvalid=1 with bresp, and enter W_RESP.
REQ-015 SHALL apply byte lane b only when wstrb[b]=1; wstrb=4'b0000 SHALL change no register, raise no wr_pulse_o bit, and still respond OKAY.
REQ-016 SHALL, on a write that is out-of-range or targets index NUM_REGS-1, change no register, raise no wr_pulse_o bit, and respond SLVERR.
REQ-017 SHALL hold bvalid and bresp stable in W_RESP until bready=1, then clear bvalid and return to W_IDLE; awready and wready SHALL be 0 throughout W_RESP.
REQ-018 SHALL implement a read FSM with states R_IDLE (arready=1) and R_DATA (arready=0).
REQ-019 SHALL, on arvalid in R_IDLE, register rdata and rresp and assert rvalid the next cycle (one-cycle latency).
REQ-020 SHALL return the register value, or status_i sampled at the arvalid handshake cycle for index NUM_REGS-1, with OKAY for in-range reads.
REQ-021 SHALL return rdata=0 with SLVERR for out-of-range reads.
REQ-022 SHALL hold rvalid, rdata and rresp stable until rready=1, then return to R_IDLE.
REQ-023 SHALL run the read and write FSMs independently; a read handshaked in the same cycle the write is applied SHALL return the pre-write value.
REQ-024 SHALL drive regs_o directly from the register flops, with no output latency beyond the write cycle.

Reset
REQ-025 SHALL, while rst=1 at a clk edge, set all R/W registers to RESET_VAL, both FSMs to idle, and clear latched AW/W.
REQ-026 SHALL, while rst=1, drive bvalid, rvalid, wr_pulse_o, bresp, rresp and rdata to 0; awready, wready and arready SHALL read 1 in the first cycle after rst is released.
REQ-027 SHALL abandon any in-flight transaction when rst is asserted mid-operation, without completing its write or emitting its response.

Verification
REQ-028 SHALL be tested: AW and W together, addr 0x04, data 0xDEADBEEF, strb 4'hF -> bvalid one cycle after the handshake, bresp=00, wr_pulse_o[1] pulses once, regs_o[63:32]=0xDEADBEEF.
REQ-029 SHALL be tested: W three cycles before AW, addr 0x08, data 0x11223344, strb 4'b0101 over 0 -> reg2=0x00220044.
REQ-030 SHALL be tested: write 0x20 with NUM_REGS=8 -> bresp=10; write 0x1C -> bresp=10 with no register change; read 0x1C with status_i=0xCAFE0001 -> rdata=0xCAFE0001, rresp=00.
REQ-031 SHALL be tested: read 0x04 with rready held 0 for 5 cycles -> rvalid and rdata stable, arready=0 throughout, completes when rready=1.
REQ-032 SHALL be tested: read of reg3 (0x0C) handshaked in the same cycle a write of 0x5 to reg3 is applied -> rdata is the old value; a subsequent read returns 0x5.
REQ-033 SHALL be tested: rst asserted while bvalid=1 awaiting bready -> bvalid=0 on the next edge, registers equal RESET_VAL, no response delivered afterwards.
